// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the audio-codec configuration sequencer.
//   state_t        - sequencer FSM states
//   CODEC_ADDR     - 7-bit I2C address of the codec (the master inserts it)
//   NUM_WORDS_DEF  - number of live entries in INIT_TABLE
//   INIT_TABLE     - register words {7-bit reg, 9-bit value}; unused = 16'hFFFF
package codec_cfg_pkg;

  localparam logic [6:0] CODEC_ADDR = 7'h34;

  localparam int unsigned NUM_WORDS_DEF = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_TRIG,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Word 0 resets the codec, word 10 activates the digital interface.
  localparam logic [15:0] INIT_TABLE [16] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479,
    16'h0679, 16'h0812, 16'h0A00, 16'h0C00,
    16'h0E02, 16'h1000, 16'h1201, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF
  };

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational lookup of the codec init table.
//   idx  in  4   table index
//   word out 16  register word at idx
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [15:0] word
);

  always_comb word = INIT_TABLE[idx];

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Walks the codec init table and hands each word to the 16-bit I2C master
// through its trig/txdone/ackOK handshake, retrying NACKed or stalled words.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   start    in   pulse; runs the table from word 0 (ignored while busy or txdone=0)
//   txdone   in   master idle flag
//   ackOK    in   master's final ACK result, valid once txdone has risen
//   cfg_data out  word presented to the master's d15..d0
//   trig     out  transfer request
//   busy     out  sequence in progress
//   done     out  sticky, all words ACKed
//   err      out  sticky, a word exhausted its retries
//   err_idx  out  failing word index, valid when err=1
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned GAP_CYC   = 4096,
  parameter int unsigned START_TO  = 16384,
  parameter int unsigned DONE_TO   = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        txdone,
  input  logic        ackOK,
  output logic [15:0] cfg_data,
  output logic        trig,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  err_idx
);

  // Limits compared against count+1 in 18 bits so that a 17-bit counter can
  // still reach a limit of 2^17 (DONE_TO default).
  localparam logic [17:0] GAP_L    = 18'(GAP_CYC);
  localparam logic [17:0] START_L  = 18'(START_TO);
  localparam logic [17:0] DONE_L   = 18'(DONE_TO);
  localparam logic [3:0]  RETRY_L  = 4'(MAX_RETRY);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_WORDS - 1);

  state_t      state, state_nx;
  logic [3:0]  idx;
  logic [3:0]  retry;
  logic [16:0] cnt;
  logic [17:0] cnt_p1;
  logic [15:0] rom_word;
  logic        attempt_fail;
  logic        can_retry;

  codec_cfg_rom u_rom (
    .idx  (idx),
    .word (rom_word)
  );

  assign cnt_p1    = {1'b0, cnt} + 18'd1;
  assign can_retry = (retry < RETRY_L);

  always_comb begin
    state_nx     = state;
    attempt_fail = 1'b0;
    case (state)
      ST_IDLE:      if (start && txdone) state_nx = ST_LOAD;
      ST_LOAD:      state_nx = ST_GAP;
      ST_GAP:       if (cnt_p1 == GAP_L) state_nx = ST_TRIG;
      ST_TRIG: begin
        if (!txdone)                 state_nx = ST_WAIT_DONE;
        else if (cnt_p1 == START_L)  attempt_fail = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (txdone)                  state_nx = ST_CHECK;
        else if (cnt_p1 == DONE_L)   attempt_fail = 1'b1;
      end
      ST_CHECK: begin
        if (ackOK) state_nx = (idx == LAST_IDX) ? ST_DONE : ST_LOAD;
        else       attempt_fail = 1'b1;
      end
      ST_DONE, ST_FAIL: state_nx = ST_IDLE;
      default:          state_nx = ST_IDLE;
    endcase
    // A retry goes straight back to GAP so cfg_data is not reloaded.
    if (attempt_fail) state_nx = can_retry ? ST_GAP : ST_FAIL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      retry    <= '0;
      cnt      <= '0;
      cfg_data <= '0;
      trig     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + 17'd1;
      // Outputs are decoded from the next state so they line up with it.
      trig  <= (state_nx == ST_TRIG);
      busy  <= (state_nx != ST_IDLE);

      if (state == ST_IDLE && state_nx == ST_LOAD) begin
        idx     <= '0;
        retry   <= '0;
        done    <= 1'b0;
        err     <= 1'b0;
        err_idx <= '0;
      end
      if (state == ST_LOAD) cfg_data <= rom_word;
      if (state == ST_CHECK && state_nx == ST_LOAD) begin
        idx   <= idx + 4'd1;
        retry <= '0;
      end
      if (attempt_fail && can_retry) retry <= retry + 4'd1;
      if (state_nx == ST_FAIL) begin
        err     <= 1'b1;
        err_idx <= idx;
      end
      if (state_nx == ST_DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer with a behavioural I2C master model.
// Expected frames are queued when a sequence is launched and checked as the
// master model sees each trig rise.
module tb_codec_cfg_sequencer;

  localparam int unsigned GAP   = 32;
  localparam int unsigned STO   = 200;
  localparam int unsigned DTO   = 600;
  localparam int unsigned BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst, start, txdone, ackOK;
  logic [15:0] cfg_data;
  logic        trig, busy, done, err;
  logic [3:0]  err_idx;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] sb [$];
  int          mode = 0;        // 0 ack all, 1 nack 0x0479 twice, 2 nack 0x0812 always, 3 never answer
  int          nack_cnt = 0;
  int          frames_seen = 0;

  logic [15:0] exp_tab [11] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201
  };

  always #5 clk = ~clk;

  codec_cfg_sequencer #(
    .NUM_WORDS (11),
    .MAX_RETRY (3),
    .GAP_CYC   (GAP),
    .START_TO  (STO),
    .DONE_TO   (DTO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .txdone   (txdone),
    .ackOK    (ackOK),
    .cfg_data (cfg_data),
    .trig     (trig),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_idx  (err_idx)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_words(input int first, input int last);
    for (int i = first; i <= last; i++) sb.push_back({16'h0, exp_tab[i]});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_val("run_end_busy", {31'h0, busy}, 32'd0);
    check_val("sb_empty", sb.size(), 32'd0);
    sb.delete();
  endtask

  // Master model: watches trig, answers with a short frame.
  initial begin : master
    int unsigned low = 0;
    int unsigned n;
    logic [15:0] data;
    logic [31:0] exp_w;
    logic        ack;
    txdone = 1'b1;
    ackOK  = 1'b0;
    forever begin
      @(negedge clk);
      if (trig !== 1'b1) begin
        low++;
      end else begin
        check_val("gap_len_ok", {31'h0, (low >= GAP)}, 32'd1);
        frames_seen++;
        data  = cfg_data;
        exp_w = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_0000;
        check_val("frame", {16'h0, data}, exp_w);
        if (mode == 3) begin
          n = 0;
          while (trig && n < 1000) begin
            @(negedge clk);
            n++;
          end
          check_val("trig_hi_len", n, STO);
        end else begin
          repeat (3) @(negedge clk);
          txdone = 1'b0;
          repeat (20) @(negedge clk);
          ack = 1'b1;
          if (mode == 1 && data == 16'h0479 && nack_cnt < 2) begin
            ack = 1'b0;
            nack_cnt++;
          end
          if (mode == 2 && data == 16'h0812) ack = 1'b0;
          ackOK  = ack;
          txdone = 1'b1;
        end
        low = 1;
      end
    end
  end

  initial begin : main
    int n;
    int base;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_cfg_data", {16'h0, cfg_data}, 32'h0);
    check_val("rst_trig",     {31'h0, trig},     32'd0);
    check_val("rst_busy",     {31'h0, busy},     32'd0);
    check_val("rst_done",     {31'h0, done},     32'd0);
    check_val("rst_err",      {31'h0, err},      32'd0);
    check_val("rst_err_idx",  {28'h0, err_idx},  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: all words ACKed
    mode = 0;
    push_words(0, 10);
    pulse_start();
    check_val("busy_after_start", {31'h0, busy}, 32'd1);
    wait_end();
    check_val("t1_done", {31'h0, done}, 32'd1);
    check_val("t1_err",  {31'h0, err},  32'd0);

    // 2: word 3 NACKed twice then ACKed
    mode = 1;
    nack_cnt = 0;
    push_words(0, 3);
    push_words(3, 3);
    push_words(3, 10);
    pulse_start();
    wait_end();
    check_val("t2_done", {31'h0, done}, 32'd1);
    check_val("t2_err",  {31'h0, err},  32'd0);

    // 3: word 5 always NACKed
    mode = 2;
    push_words(0, 4);
    repeat (4) push_words(5, 5);
    pulse_start();
    wait_end();
    check_val("t3_err",     {31'h0, err},     32'd1);
    check_val("t3_err_idx", {28'h0, err_idx}, 32'd5);
    check_val("t3_done",    {31'h0, done},    32'd0);

    // 4: txdone never falls
    mode = 3;
    repeat (4) push_words(0, 0);
    pulse_start();
    wait_end();
    check_val("t4_err",     {31'h0, err},     32'd1);
    check_val("t4_err_idx", {28'h0, err_idx}, 32'd0);
    check_val("t4_trig",    {31'h0, trig},    32'd0);

    // 5: reset during the second frame
    mode = 0;
    base = frames_seen;
    push_words(0, 1);
    pulse_start();
    n = 0;
    while (!(frames_seen >= base + 2 && !txdone) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_val("t5_frames_before_rst", frames_seen - base, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t5_rst_trig", {31'h0, trig}, 32'd0);
    check_val("t5_rst_busy", {31'h0, busy}, 32'd0);
    check_val("t5_txdone_low", {31'h0, txdone}, 32'd0);
    pulse_start();
    @(negedge clk);
    check_val("t5_start_ignored", {31'h0, busy}, 32'd0);
    n = 0;
    while (!txdone && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_val("t5_txdone_rise", {31'h0, txdone}, 32'd1);
    check_val("t5_sb_empty", sb.size(), 32'd0);
    push_words(0, 10);
    pulse_start();
    wait_end();
    check_val("t5_done", {31'h0, done}, 32'd1);

    // 6: start while busy is ignored
    base = frames_seen;
    push_words(0, 10);
    pulse_start();
    n = 0;
    while (frames_seen < base + 3 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    pulse_start();
    wait_end();
    check_val("t6_frames", frames_seen - base, 32'd11);
    check_val("t6_done", {31'h0, done}, 32'd1);
    check_val("t6_err",  {31'h0, err},  32'd0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
